// File: rtl/if_fetch_stage_pkg.sv
// Shared constants for the instruction-fetch stage: stall bus encoding,
// branch bus width and default fetch geometry.
package if_fetch_stage_pkg;

  localparam int          STALL_W      = 6;
  localparam logic        STOP         = 1'b1;
  localparam logic        NO_STOP      = 1'b0;
  localparam int          BR_WD        = 33;
  localparam int          DEF_FETCH_W  = 2;
  localparam logic [31:0] DEF_RESET_PC = 32'hbfc0_0000;

  // {ce, adel, mask[fetch_w-1:0], pc[31:0]}
  function automatic int if_to_id_wd(input int fetch_w);
    return 34 + fetch_w;
  endfunction

endpackage

// File: rtl/if_fetch_stage_pc_sel.sv
// Next-fetch target priority (flush > branch > pending > sequential) and the
// derived aligned address, slot-valid mask and misalignment flag.
module if_fetch_stage_pc_sel #(
  parameter int FETCH_W = 2
) (
  input  logic               flush,
  input  logic [31:0]        new_pc,
  input  logic               br_e,
  input  logic [31:0]        br_addr,
  input  logic               pend_v,
  input  logic [31:0]        pend_addr,
  input  logic [31:0]        pc,
  output logic [31:0]        next_pc,
  output logic [FETCH_W-1:0] next_mask,
  output logic               next_adel
);

  localparam int          OFF    = $clog2(FETCH_W) + 2;
  localparam int          SLOT_W = (OFF > 2) ? OFF - 2 : 1;
  localparam logic [31:0] STEP   = 32'(4 * FETCH_W);

  logic [31:0]       target;
  logic [SLOT_W-1:0] slot;

  always_comb begin
    if (flush)       target = new_pc;
    else if (br_e)   target = br_addr;
    else if (pend_v) target = pend_addr;
    else             target = pc + STEP;
  end

  generate
    if (FETCH_W > 1) begin : g_slot
      assign slot = target[OFF-1:2];
    end else begin : g_noslot
      assign slot = '0;
    end
  endgenerate

  // Slots below the target's slot in the fetch line are not executed.
  always_comb begin
    next_mask = '0;
    for (int i = 0; i < FETCH_W; i++) begin
      next_mask[i] = (32'(i) >= 32'(slot));
    end
  end

  assign next_pc   = {target[31:OFF], {OFF{1'b0}}};
  assign next_adel = (target[1:0] != 2'b00);

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: holds the fetch PC, issues aligned line fetches and
// buffers an EX branch redirect that lands while the stage is stalled.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter int          FETCH_W  = DEF_FETCH_W
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [STALL_W-1:0]                 stall,
  input  logic                               flush,
  input  logic [31:0]                        new_pc,
  input  logic [BR_WD-1:0]                   br_bus,
  output logic [if_to_id_wd(FETCH_W)-1:0]    if_to_id_bus,
  output logic                               inst_sram_en,
  output logic [3:0]                         inst_sram_wen,
  output logic [31:0]                        inst_sram_addr,
  output logic [31:0]                        inst_sram_wdata
);

  localparam int          OFF      = $clog2(FETCH_W) + 2;
  localparam logic [31:0] STEP     = 32'(4 * FETCH_W);
  localparam logic [31:0] PC_RESET = {RESET_PC[31:OFF], {OFF{1'b0}}} - STEP;

  logic               br_e;
  logic [31:0]        br_addr;
  logic               update;
  logic               stall_unused;

  logic [31:0]        pc;
  logic               ce;
  logic [FETCH_W-1:0] mask;
  logic               adel;
  logic               pend_v;
  logic [31:0]        pend_addr;

  logic [31:0]        next_pc;
  logic [FETCH_W-1:0] next_mask;
  logic               next_adel;

  assign {br_e, br_addr} = br_bus;
  assign stall_unused    = ^stall[STALL_W-1:1];

  // A flush always lands, even under stall; CTRL kills the flushed slot in ID.
  assign update = flush | (stall[0] == NO_STOP);

  if_fetch_stage_pc_sel #(
    .FETCH_W (FETCH_W)
  ) u_pc_sel (
    .flush     (flush),
    .new_pc    (new_pc),
    .br_e      (br_e),
    .br_addr   (br_addr),
    .pend_v    (pend_v),
    .pend_addr (pend_addr),
    .pc        (pc),
    .next_pc   (next_pc),
    .next_mask (next_mask),
    .next_adel (next_adel)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= PC_RESET;
      ce        <= 1'b0;
      mask      <= '0;
      adel      <= 1'b0;
      pend_v    <= 1'b0;
      pend_addr <= '0;
    end else if (update) begin
      pc     <= next_pc;
      mask   <= next_mask;
      adel   <= next_adel;
      ce     <= 1'b1;
      pend_v <= 1'b0;
    end else begin
      ce <= 1'b0;
      if (br_e) begin
        pend_v    <= 1'b1;
        pend_addr <= br_addr;
      end
    end
  end

  assign if_to_id_bus    = {ce, adel, mask, pc};
  assign inst_sram_en    = ce;
  assign inst_sram_wen   = 4'h0;
  assign inst_sram_addr  = pc;
  assign inst_sram_wdata = 32'h0;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench: three fetch widths (1, 2, 4) share one stimulus stream
// and are compared every cycle against a line-arithmetic reference model.
module tb_if_fetch_stage;
  import if_fetch_stage_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [STALL_W-1:0] stall = '0;
  logic              flush = 1'b0;
  logic [31:0]       new_pc = '0;
  logic              br_e = 1'b0;
  logic [31:0]       br_addr = '0;
  logic [BR_WD-1:0]  br_bus;

  assign br_bus = {br_e, br_addr};

  logic [34:0] bus1;
  logic [35:0] bus2;
  logic [37:0] bus4;
  logic        en1, en2, en4;
  logic [3:0]  wen1, wen2, wen4;
  logic [31:0] addr1, addr2, addr4;
  logic [31:0] wd1, wd2, wd4;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  if_fetch_stage #(.RESET_PC(32'hbfc0_0000), .FETCH_W(1)) dut1 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .new_pc(new_pc),
    .br_bus(br_bus), .if_to_id_bus(bus1), .inst_sram_en(en1),
    .inst_sram_wen(wen1), .inst_sram_addr(addr1), .inst_sram_wdata(wd1));

  if_fetch_stage #(.RESET_PC(32'hbfc0_0000), .FETCH_W(2)) dut2 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .new_pc(new_pc),
    .br_bus(br_bus), .if_to_id_bus(bus2), .inst_sram_en(en2),
    .inst_sram_wen(wen2), .inst_sram_addr(addr2), .inst_sram_wdata(wd2));

  if_fetch_stage #(.RESET_PC(32'hbfc0_0000), .FETCH_W(4)) dut4 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .new_pc(new_pc),
    .br_bus(br_bus), .if_to_id_bus(bus4), .inst_sram_en(en4),
    .inst_sram_wen(wen4), .inst_sram_addr(addr4), .inst_sram_wdata(wd4));

  // Reference model, index k covers FETCH_W = 1 << k.
  logic [31:0] m_pc   [3];
  logic        m_ce   [3];
  logic [3:0]  m_mask [3];
  logic        m_adel [3];
  logic        m_pv   [3];
  logic [31:0] m_pa   [3];

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      int unsigned w, step, slot;
      logic [31:0] t;
      w    = 1 << k;
      step = 4 * w;
      if (rst) begin
        m_pc[k]   = 32'hbfc0_0000 - step;
        m_ce[k]   = 1'b0;
        m_mask[k] = 4'h0;
        m_adel[k] = 1'b0;
        m_pv[k]   = 1'b0;
        m_pa[k]   = 32'h0;
      end else if (flush || !stall[0]) begin
        if (flush)         t = new_pc;
        else if (br_e)     t = br_addr;
        else if (m_pv[k])  t = m_pa[k];
        else               t = m_pc[k] + step;
        slot      = (t % step) / 4;
        m_pc[k]   = t - (t % step);
        m_mask[k] = 4'h0;
        for (int i = 0; i < 4; i++)
          if (i < w && i >= slot) m_mask[k][i] = 1'b1;
        m_adel[k] = (t % 4) != 0;
        m_ce[k]   = 1'b1;
        m_pv[k]   = 1'b0;
      end else begin
        m_ce[k] = 1'b0;
        if (br_e) begin
          m_pv[k] = 1'b1;
          m_pa[k] = br_addr;
        end
      end
    end
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_inst(input int k, input logic [31:0] pc, input logic [3:0] mask,
                            input logic adel, input logic ce, input logic en,
                            input logic [3:0] wen, input logic [31:0] addr,
                            input logic [31:0] wd);
    string p;
    p = $sformatf("w%0d", 1 << k);
    cmp({p, "_pc"},    pc,         m_pc[k]);
    cmp({p, "_mask"},  32'(mask),  32'(m_mask[k]));
    cmp({p, "_adel"},  32'(adel),  32'(m_adel[k]));
    cmp({p, "_ce"},    32'(ce),    32'(m_ce[k]));
    cmp({p, "_en"},    32'(en),    32'(m_ce[k]));
    cmp({p, "_addr"},  addr,       m_pc[k]);
    cmp({p, "_wen"},   32'(wen),   32'h0);
    cmp({p, "_wdata"}, wd,         32'h0);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check_inst(0, bus1[31:0], {3'b000, bus1[32]},  bus1[33], bus1[34], en1, wen1, addr1, wd1);
      check_inst(1, bus2[31:0], {2'b00, bus2[33:32]}, bus2[34], bus2[35], en2, wen2, addr2, wd2);
      check_inst(2, bus4[31:0], bus4[35:32],          bus4[36], bus4[37], en4, wen4, addr4, wd4);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Literal expectation checked against both the DUT and the model.
  task automatic lit(input string name, input logic [31:0] dut_v,
                     input logic [31:0] mdl_v, input logic [31:0] exp);
    cmp({name, "_dut"}, dut_v, exp);
    cmp({name, "_mdl"}, mdl_v, exp);
  endtask

  initial begin
    rst = 1'b1;
    tick();
    tick();
    chk_en = 1'b1;
    lit("rst_addr", addr2, m_pc[1], 32'hbfbf_fff8);
    lit("rst_ce",   32'(en2), 32'(m_ce[1]), 32'h0);
    lit("rst_mask", 32'(bus2[33:32]), 32'(m_mask[1]), 32'h0);

    rst = 1'b0;
    tick();
    lit("first_addr", addr2, m_pc[1], 32'hbfc0_0000);
    lit("first_ce",   32'(en2), 32'(m_ce[1]), 32'h1);
    lit("first_mask", 32'(bus2[33:32]), 32'(m_mask[1]), 32'h3);
    tick();
    lit("seq1_addr", addr2, m_pc[1], 32'hbfc0_0008);
    tick();
    lit("seq2_addr", addr2, m_pc[1], 32'hbfc0_0010);

    br_e = 1'b1; br_addr = 32'hbfc0_0104;
    tick();
    br_e = 1'b0;
    lit("br_addr",   addr2, m_pc[1], 32'hbfc0_0100);
    lit("br_mask",   32'(bus2[33:32]), 32'(m_mask[1]), 32'h2);
    lit("br_adel",   32'(bus2[34]), 32'(m_adel[1]), 32'h0);
    lit("br_mask_w4", 32'(bus4[35:32]), 32'(m_mask[2]), 32'he);

    stall[0] = 1'b1; br_e = 1'b1; br_addr = 32'h8000_0020;
    tick();
    br_e = 1'b0;
    lit("stl_addr", addr2, m_pc[1], 32'hbfc0_0100);
    lit("stl_ce",   32'(en2), 32'(m_ce[1]), 32'h0);
    tick();
    tick();
    lit("stl3_addr", addr2, m_pc[1], 32'hbfc0_0100);
    stall[0] = 1'b0;
    tick();
    lit("pend_addr", addr2, m_pc[1], 32'h8000_0020);
    lit("pend_ce",   32'(en2), 32'(m_ce[1]), 32'h1);
    tick();
    lit("pend_clr", addr2, m_pc[1], 32'h8000_0028);

    flush = 1'b1; new_pc = 32'hbfc0_0380; br_e = 1'b1; br_addr = 32'h1234_5678; stall[0] = 1'b1;
    tick();
    flush = 1'b0; br_e = 1'b0;
    lit("fl_addr", addr2, m_pc[1], 32'hbfc0_0380);
    lit("fl_ce",   32'(en2), 32'(m_ce[1]), 32'h1);
    tick();
    lit("fl_hold", addr2, m_pc[1], 32'hbfc0_0380);
    stall[0] = 1'b0;
    tick();
    lit("fl_nobr", addr2, m_pc[1], 32'hbfc0_0388);

    br_e = 1'b1; br_addr = 32'h0000_0102;
    tick();
    br_e = 1'b0;
    lit("mis_addr", addr2, m_pc[1], 32'h0000_0100);
    lit("mis_adel", 32'(bus2[34]), 32'(m_adel[1]), 32'h1);
    lit("mis_mask", 32'(bus2[33:32]), 32'(m_mask[1]), 32'h3);
    tick();
    lit("mis_next_adel", 32'(bus2[34]), 32'(m_adel[1]), 32'h0);

    br_e = 1'b1; br_addr = 32'hffff_fff8;
    tick();
    br_e = 1'b0;
    lit("wrap2_pre", addr2, m_pc[1], 32'hffff_fff8);
    tick();
    lit("wrap2", addr2, m_pc[1], 32'h0000_0000);

    br_e = 1'b1; br_addr = 32'hffff_fff0;
    tick();
    br_e = 1'b0;
    lit("wrap4_pre", addr4, m_pc[2], 32'hffff_fff0);
    tick();
    lit("wrap4", addr4, m_pc[2], 32'h0000_0000);

    for (int c = 0; c < 600; c++) begin
      rst      = ($urandom_range(0, 99) < 2);
      stall    = STALL_W'($urandom);
      stall[0] = ($urandom_range(0, 99) < 35);
      flush    = ($urandom_range(0, 99) < 6);
      new_pc   = $urandom;
      br_e     = ($urandom_range(0, 99) < 25);
      br_addr  = ($urandom_range(0, 1) == 0) ? ($urandom & 32'hffff_fffc) : $urandom;
      tick();
    end
    rst = 1'b0; stall = '0; flush = 1'b0; br_e = 1'b0;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
